// File: rtl/vga_timing_driver.sv
// vga_timing_driver
//   VGA raster engine driving an ADV7123-style DAC directly. Generates
//   programmable H/V timing from a system clock divided by DIV, requests
//   pixels from an upstream source with a one-clock ready pulse, expands
//   COLOR_W-bit channels to 8 bits and flags sticky pixel underflow.
//
// Ports
//   ul1Clock, ul1Reset        system clock, asynchronous active-high reset
//   ul1Enable                 run raster; low holds everything at reset values
//   ulPixData, ul1PixValid    {R,G,B} pixel from the frame source and its valid
//   ul1PixReady               one-clock request for the pixel at ulHCount/ulVCount
//   ulHCount, ulVCount        raster position evaluated this clock
//   ul1FrameStart             one-clock pulse on the tick of pixel (0,0)
//   ul1Underflow, ul1UnderflowClr  sticky underflow flag and its clear
//   ul1VgaClock               DAC pixel clock (rises mid-pixel)
//   ul8VgaRed/Green/Blue      DAC colour data
//   ul1VgaBlank_n             low outside the active area
//   ul1VgaHSync, ul1VgaVSync  syncs with HS_POL / VS_POL active level
//   ul1VgaSync_n              composite sync, unused and held high
module vga_timing_driver #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int COLOR_W  = 8,
  parameter int DIV      = 2,
  parameter int CNT_W    = 12
) (
  input  logic                   ul1Clock,
  input  logic                   ul1Reset,
  input  logic                   ul1Enable,
  input  logic [3*COLOR_W-1:0]   ulPixData,
  input  logic                   ul1PixValid,
  output logic                   ul1PixReady,
  output logic [CNT_W-1:0]       ulHCount,
  output logic [CNT_W-1:0]       ulVCount,
  output logic                   ul1FrameStart,
  output logic                   ul1Underflow,
  input  logic                   ul1UnderflowClr,
  output logic                   ul1VgaClock,
  output logic [7:0]             ul8VgaRed,
  output logic [7:0]             ul8VgaGreen,
  output logic [7:0]             ul8VgaBlue,
  output logic                   ul1VgaBlank_n,
  output logic                   ul1VgaHSync,
  output logic                   ul1VgaVSync,
  output logic                   ul1VgaSync_n
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = $clog2(DIV);

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] H_SYNC_S = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] H_SYNC_E = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] V_SYNC_S = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] V_SYNC_E = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(DIV / 2);

  // Repeat the channel pattern MSB-first and keep the top 8 bits, so full
  // scale maps to 8'hFF and zero to 8'h00 for any width.
  function automatic logic [7:0] expand(input logic [COLOR_W-1:0] c);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      r[7-i] = c[COLOR_W-1-(i % COLOR_W)];
    end
    return r;
  endfunction

  logic [DIV_W-1:0] div_p0;
  logic [CNT_W-1:0] h_p0;
  logic [CNT_W-1:0] v_p0;
  logic             tick_p0;
  logic             active_p0;
  logic             hs_on_p0;
  logic             vs_on_p0;
  logic             take_p0;

  logic [7:0]       red_p1;
  logic [7:0]       green_p1;
  logic [7:0]       blue_p1;
  logic             blank_n_p1;
  logic             hsync_p1;
  logic             vsync_p1;
  logic             vga_clk_p1;
  logic             underflow;

  // Stage 0: raster position and tick decode (combinational from counters).
  // Reset is folded into the tick so the request/frame pulses are quiet
  // while reset is held, even with enable high.
  assign tick_p0   = ul1Enable && !ul1Reset && (div_p0 == '0);
  assign active_p0 = (h_p0 < H_ACT) && (v_p0 < V_ACT);
  assign hs_on_p0  = (h_p0 >= H_SYNC_S) && (h_p0 < H_SYNC_E);
  assign vs_on_p0  = (v_p0 >= V_SYNC_S) && (v_p0 < V_SYNC_E);
  assign take_p0   = tick_p0 && active_p0;

  assign ul1PixReady   = take_p0;
  assign ul1FrameStart = tick_p0 && (h_p0 == '0) && (v_p0 == '0);
  assign ulHCount      = h_p0;
  assign ulVCount      = v_p0;

  always_ff @(posedge ul1Clock or posedge ul1Reset) begin
    if (ul1Reset) begin
      div_p0 <= '0;
      h_p0   <= '0;
      v_p0   <= '0;
    end else if (!ul1Enable) begin
      div_p0 <= '0;
      h_p0   <= '0;
      v_p0   <= '0;
    end else begin
      div_p0 <= (div_p0 == DIV_LAST) ? '0 : div_p0 + 1'b1;
      if (tick_p0) begin
        if (h_p0 == H_LAST) begin
          h_p0 <= '0;
          v_p0 <= (v_p0 == V_LAST) ? '0 : v_p0 + 1'b1;
        end else begin
          h_p0 <= h_p0 + 1'b1;
        end
      end
    end
  end

  // Sticky underflow survives disable; a new underflow beats a clear.
  always_ff @(posedge ul1Clock or posedge ul1Reset) begin
    if (ul1Reset) begin
      underflow <= 1'b0;
    end else if (take_p0 && !ul1PixValid) begin
      underflow <= 1'b1;
    end else if (ul1UnderflowClr) begin
      underflow <= 1'b0;
    end
  end

  // Stage 1: DAC output registers, loaded on the edge ending each tick and
  // held for DIV clocks. The pixel clock falls on that edge and rises
  // DIV/2 clocks later so the DAC samples in the middle of the pixel.
  always_ff @(posedge ul1Clock or posedge ul1Reset) begin
    if (ul1Reset) begin
      red_p1     <= 8'h00;
      green_p1   <= 8'h00;
      blue_p1    <= 8'h00;
      blank_n_p1 <= 1'b0;
      hsync_p1   <= ~HS_POL;
      vsync_p1   <= ~VS_POL;
      vga_clk_p1 <= 1'b0;
    end else if (!ul1Enable) begin
      red_p1     <= 8'h00;
      green_p1   <= 8'h00;
      blue_p1    <= 8'h00;
      blank_n_p1 <= 1'b0;
      hsync_p1   <= ~HS_POL;
      vsync_p1   <= ~VS_POL;
      vga_clk_p1 <= 1'b0;
    end else begin
      if (tick_p0) begin
        red_p1     <= (take_p0 && ul1PixValid) ? expand(ulPixData[3*COLOR_W-1 -: COLOR_W]) : 8'h00;
        green_p1   <= (take_p0 && ul1PixValid) ? expand(ulPixData[2*COLOR_W-1 -: COLOR_W]) : 8'h00;
        blue_p1    <= (take_p0 && ul1PixValid) ? expand(ulPixData[COLOR_W-1:0])           : 8'h00;
        blank_n_p1 <= active_p0;
        hsync_p1   <= hs_on_p0 ? HS_POL : ~HS_POL;
        vsync_p1   <= vs_on_p0 ? VS_POL : ~VS_POL;
        vga_clk_p1 <= 1'b0;
      end else if (div_p0 == DIV_HALF) begin
        vga_clk_p1 <= 1'b1;
      end
    end
  end

  assign ul8VgaRed     = red_p1;
  assign ul8VgaGreen   = green_p1;
  assign ul8VgaBlue    = blue_p1;
  assign ul1VgaBlank_n = blank_n_p1;
  assign ul1VgaHSync   = hsync_p1;
  assign ul1VgaVSync   = vsync_p1;
  assign ul1VgaClock   = vga_clk_p1;
  assign ul1VgaSync_n  = 1'b1;
  assign ul1Underflow  = underflow;

endmodule

// File: tb/tb_vga_timing_driver.sv
// Directed testbench for vga_timing_driver: one instance with default
// 640x480 timing and 8-bit colour, one with a small 14x7 raster and
// 5-bit colour for frame-level, underflow and enable behaviour.
module tb_vga_timing_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // default-timing instance
  logic        d_en, d_valid, d_clr;
  logic [23:0] d_data;
  logic        d_ready, d_fs, d_uf, d_vclk, d_blank, d_hs, d_vs, d_sync;
  logic [11:0] d_hc, d_vc;
  logic [7:0]  d_r, d_g, d_b;

  // small-raster instance
  logic        s_en, s_valid, s_clr;
  logic [14:0] s_data;
  logic        s_ready, s_fs, s_uf, s_vclk, s_blank, s_hs, s_vs, s_sync;
  logic [11:0] s_hc, s_vc;
  logic [7:0]  s_r, s_g, s_b;

  vga_timing_driver u_dflt (
    .ul1Clock(clk), .ul1Reset(rst), .ul1Enable(d_en),
    .ulPixData(d_data), .ul1PixValid(d_valid), .ul1PixReady(d_ready),
    .ulHCount(d_hc), .ulVCount(d_vc), .ul1FrameStart(d_fs),
    .ul1Underflow(d_uf), .ul1UnderflowClr(d_clr), .ul1VgaClock(d_vclk),
    .ul8VgaRed(d_r), .ul8VgaGreen(d_g), .ul8VgaBlue(d_b),
    .ul1VgaBlank_n(d_blank), .ul1VgaHSync(d_hs), .ul1VgaVSync(d_vs),
    .ul1VgaSync_n(d_sync)
  );

  vga_timing_driver #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .COLOR_W(5), .DIV(2)
  ) u_small (
    .ul1Clock(clk), .ul1Reset(rst), .ul1Enable(s_en),
    .ulPixData(s_data), .ul1PixValid(s_valid), .ul1PixReady(s_ready),
    .ulHCount(s_hc), .ulVCount(s_vc), .ul1FrameStart(s_fs),
    .ul1Underflow(s_uf), .ul1UnderflowClr(s_clr), .ul1VgaClock(s_vclk),
    .ul8VgaRed(s_r), .ul8VgaGreen(s_g), .ul8VgaBlue(s_b),
    .ul1VgaBlank_n(s_blank), .ul1VgaHSync(s_hs), .ul1VgaVSync(s_vs),
    .ul1VgaSync_n(s_sync)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_d(input string p);
    chk({p, " d_ready"}, 32'(d_ready), 32'd0);
    chk({p, " d_fs"},    32'(d_fs),    32'd0);
    chk({p, " d_hc"},    32'(d_hc),    32'd0);
    chk({p, " d_vc"},    32'(d_vc),    32'd0);
    chk({p, " d_uf"},    32'(d_uf),    32'd0);
    chk({p, " d_vclk"},  32'(d_vclk),  32'd0);
    chk({p, " d_rgb"},   32'({d_r, d_g, d_b}), 32'd0);
    chk({p, " d_blank"}, 32'(d_blank), 32'd0);
    chk({p, " d_hs"},    32'(d_hs),    32'd1);
    chk({p, " d_vs"},    32'(d_vs),    32'd1);
    chk({p, " d_sync"},  32'(d_sync),  32'd1);
  endtask

  task automatic chk_reset_s(input string p);
    chk({p, " s_ready"}, 32'(s_ready), 32'd0);
    chk({p, " s_fs"},    32'(s_fs),    32'd0);
    chk({p, " s_hc"},    32'(s_hc),    32'd0);
    chk({p, " s_uf"},    32'(s_uf),    32'd0);
    chk({p, " s_vclk"},  32'(s_vclk),  32'd0);
    chk({p, " s_rgb"},   32'({s_r, s_g, s_b}), 32'd0);
    chk({p, " s_blank"}, 32'(s_blank), 32'd0);
    chk({p, " s_hs"},    32'(s_hs),    32'd1);
    chk({p, " s_vs"},    32'(s_vs),    32'd1);
  endtask

  int d_blank_cnt = 0, d_hs_cnt = 0, d_hs_first = -1, d_vclk_cnt = 0;
  int s_rdy_cnt = 0, s_rdy_l0 = 0, s_vs_cnt = 0, s_vs_first = -1;
  int s_hs_cnt = 0, s_hs_first = -1, s_fs_next = -1;

  initial begin
    rst = 1'b1;
    d_en = 1'b0; s_en = 1'b0;
    d_valid = 1'b1; s_valid = 1'b1;
    d_clr = 1'b0; s_clr = 1'b0;
    d_data = 24'h123456;
    s_data = {5'h1F, 5'h10, 5'h00};

    repeat (3) next_cyc();
    rst = 1'b0;
    repeat (2) next_cyc();

    // run a few pixels, then hit reset asynchronously mid-line
    d_en = 1'b1; s_en = 1'b1;
    repeat (10) next_cyc();
    chk("pre_reset d_blank", 32'(d_blank), 32'd1);
    chk("pre_reset s_blank", 32'(s_blank), 32'd1);
    #3 rst = 1'b1;
    #1;
    chk_reset_d("async_rst");
    chk_reset_s("async_rst");
    d_en = 1'b0; s_en = 1'b0;
    next_cyc();
    rst = 1'b0;
    repeat (3) next_cyc();
    chk_reset_d("disabled");
    chk_reset_s("disabled");

    // enable both; cycle k=0 is the tick of pixel (0,0)
    d_en = 1'b1; s_en = 1'b1;
    for (int k = 0; k <= 1600; k++) begin
      s_valid = !(k == 34 || k == 196);
      s_clr   = (k == 196 || k == 270);
      s_en    = !(k >= 262 && k <= 265);
      #1;

      if (d_blank) d_blank_cnt++;
      if (d_vclk) d_vclk_cnt++;
      if (!d_hs) begin
        if (d_hs_first < 0) d_hs_first = k;
        d_hs_cnt++;
      end
      if (k < 196) begin
        if (s_ready) s_rdy_cnt++;
        if (s_ready && k < 28) s_rdy_l0++;
        if (!s_vs) begin
          if (s_vs_first < 0) s_vs_first = k;
          s_vs_cnt++;
        end
        if (!s_hs && k < 28) begin
          if (s_hs_first < 0) s_hs_first = k;
          s_hs_cnt++;
        end
      end
      if (k > 0 && s_fs && s_fs_next < 0) s_fs_next = k;

      case (k)
        0: begin
          chk("k0 d_fs", 32'(d_fs), 32'd1);
          chk("k0 s_fs", 32'(s_fs), 32'd1);
          chk("k0 d_ready", 32'(d_ready), 32'd1);
          chk("k0 s_ready", 32'(s_ready), 32'd1);
          chk("k0 d_hc", 32'(d_hc), 32'd0);
        end
        1: begin
          chk("k1 d_rgb", 32'({d_r, d_g, d_b}), 32'h123456);
          chk("k1 d_blank", 32'(d_blank), 32'd1);
          chk("k1 d_vclk", 32'(d_vclk), 32'd0);
          chk("k1 s_red", 32'(s_r), 32'hFF);
          chk("k1 s_green", 32'(s_g), 32'h84);
          chk("k1 s_blue", 32'(s_b), 32'h00);
        end
        2: chk("k2 d_vclk", 32'(d_vclk), 32'd1);
        3: chk("k3 d_vclk", 32'(d_vclk), 32'd0);
        33: begin
          chk("k33 s_red", 32'(s_r), 32'hFF);
          chk("k33 s_uf", 32'(s_uf), 32'd0);
        end
        34: begin
          chk("k34 s_hc", 32'(s_hc), 32'd3);
          chk("k34 s_vc", 32'(s_vc), 32'd1);
          chk("k34 s_ready", 32'(s_ready), 32'd1);
          chk("k34 s_uf", 32'(s_uf), 32'd0);
        end
        35: begin
          chk("ufl s_rgb", 32'({s_r, s_g, s_b}), 32'd0);
          chk("ufl s_blank", 32'(s_blank), 32'd1);
          chk("ufl s_uf", 32'(s_uf), 32'd1);
        end
        195: chk("sticky s_uf", 32'(s_uf), 32'd1);
        196: begin
          chk("k196 s_fs", 32'(s_fs), 32'd1);
          chk("k196 s_ready", 32'(s_ready), 32'd1);
        end
        197: begin
          chk("set_beats_clr s_uf", 32'(s_uf), 32'd1);
          chk("k197 s_rgb", 32'({s_r, s_g, s_b}), 32'd0);
          chk("k197 s_blank", 32'(s_blank), 32'd1);
        end
        262: begin
          chk("k262 s_hc", 32'(s_hc), 32'd5);
          chk("k262 s_vc", 32'(s_vc), 32'd2);
          chk("k262 s_blank", 32'(s_blank), 32'd1);
        end
        263: begin
          chk("dis s_blank", 32'(s_blank), 32'd0);
          chk("dis s_rgb", 32'({s_r, s_g, s_b}), 32'd0);
          chk("dis s_hs", 32'(s_hs), 32'd1);
          chk("dis s_vs", 32'(s_vs), 32'd1);
          chk("dis s_hc", 32'(s_hc), 32'd0);
          chk("dis s_vc", 32'(s_vc), 32'd0);
          chk("dis s_uf_kept", 32'(s_uf), 32'd1);
          chk("dis s_ready", 32'(s_ready), 32'd0);
        end
        264: chk("dis s_vclk", 32'(s_vclk), 32'd0);
        265: chk("dis s_fs", 32'(s_fs), 32'd0);
        266: begin
          chk("reen s_fs", 32'(s_fs), 32'd1);
          chk("reen s_ready", 32'(s_ready), 32'd1);
          chk("reen s_hc", 32'(s_hc), 32'd0);
          chk("reen s_vc", 32'(s_vc), 32'd0);
        end
        267: begin
          chk("reen s_blank", 32'(s_blank), 32'd1);
          chk("reen s_red", 32'(s_r), 32'hFF);
          chk("reen s_green", 32'(s_g), 32'h84);
        end
        270: begin
          chk("k270 s_uf", 32'(s_uf), 32'd1);
          chk("k270 s_hc", 32'(s_hc), 32'd2);
        end
        271: chk("clr s_uf", 32'(s_uf), 32'd0);
        1312: begin
          chk("k1312 d_hc", 32'(d_hc), 32'd656);
          chk("k1312 d_vc", 32'(d_vc), 32'd0);
        end
        1600: begin
          chk("k1600 d_hc", 32'(d_hc), 32'd0);
          chk("k1600 d_vc", 32'(d_vc), 32'd1);
          chk("k1600 d_fs", 32'(d_fs), 32'd0);
        end
        default: ;
      endcase

      next_cyc();
    end

    chk("d blank clocks/line", 32'(d_blank_cnt), 32'd1280);
    chk("d hsync first low", 32'(d_hs_first), 32'd1313);
    chk("d hsync low clocks", 32'(d_hs_cnt), 32'd192);
    chk("d vclk high clocks", 32'(d_vclk_cnt), 32'd800);
    chk("s ready/frame", 32'(s_rdy_cnt), 32'd32);
    chk("s ready/line", 32'(s_rdy_l0), 32'd8);
    chk("s vsync first low", 32'(s_vs_first), 32'd141);
    chk("s vsync low clocks", 32'(s_vs_cnt), 32'd28);
    chk("s hsync first low", 32'(s_hs_first), 32'd21);
    chk("s hsync low clocks", 32'(s_hs_cnt), 32'd4);
    chk("s frame period", 32'(s_fs_next), 32'd196);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
